bus_timer: RTL and testbench

//  Memory-mapped machine timer; the responder end of the data bus driven by the memory stage.

---
 rtl/bus_timer_pkg.sv | 36 +++
 rtl/bus_timer_prescaler.sv | 30 +++
 rtl/bus_timer.sv | 129 ++++++++++++
 tb/tb_bus_timer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// bit positions, reset constants and the byte-lane merge helper.
package bus_timer_pkg;

  typedef enum logic [2:0] {
    OFF_MTIME_LO = 3'd0,
    OFF_MTIME_HI = 3'd1,
    OFF_CMP_LO   = 3'd2,
    OFF_CMP_HI   = 3'd3,
    OFF_CTRL     = 3'd4,
    OFF_PRESCALE = 3'd5,
    OFF_STATUS   = 3'd6,
    OFF_RSVD     = 3'd7
  } reg_off_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STATUS_MATCH = 0;
  localparam int STATUS_SEEN  = 1;
  localparam int PRE_W        = 16;

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for the timer: counts 0..prescale while enabled and pulses tick
// on the terminal count; held at zero when disabled or explicitly cleared.
module bus_timer_prescaler
  import bus_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = en && (pre_cnt_q == prescale);

  // NOTE: every path assigns pre_cnt_d (default first), so no latch is inferred.
  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (!en || clr || tick) pre_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit compare,
// control/status registers, a combinational read port and a level timer_irq.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  output logic        timer_irq
);

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             seen_q, seen_d;
  logic             match_q, match_d;
  logic             irq_q, irq_d;

  reg_off_e off;
  logic     wr, tick, pre_clr, mtime_wr, seen_clr, match;
  logic     unused_addr_bits;

  assign bus_hit          = (bus_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign off              = reg_off_e'(bus_addr[4:2]);
  assign wr               = bus_hit && (|bus_we);
  assign pre_clr          = wr && (off == OFF_PRESCALE);
  assign mtime_wr         = wr && (off == OFF_MTIME_LO || off == OFF_MTIME_HI);
  assign seen_clr         = wr && (off == OFF_STATUS) && bus_we[0] && bus_wdata[STATUS_SEEN];
  assign match            = (mtime_q >= cmp_q);
  assign timer_irq        = irq_q;
  assign unused_addr_bits = ^bus_addr[1:0];

  bus_timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .prescale (prescale_q),
    .clr      (pre_clr),
    .tick     (tick)
  );

  always_comb begin
    mtime_d    = mtime_q;
    cmp_d      = cmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    // A software write to either mtime half takes priority over the tick.
    if (tick && !mtime_wr) mtime_d = mtime_q + 64'd1;
    if (wr) begin
      unique case (off)
        OFF_MTIME_LO: mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  bus_wdata, bus_we);
        OFF_MTIME_HI: mtime_d[63:32] = merge_bytes(mtime_q[63:32], bus_wdata, bus_we);
        OFF_CMP_LO:   cmp_d[31:0]    = merge_bytes(cmp_q[31:0],    bus_wdata, bus_we);
        OFF_CMP_HI:   cmp_d[63:32]   = merge_bytes(cmp_q[63:32],   bus_wdata, bus_we);
        OFF_CTRL: begin
          if (bus_we[0]) begin
            en_d     = bus_wdata[CTRL_EN];
            irq_en_d = bus_wdata[CTRL_IRQ_EN];
          end
        end
        OFF_PRESCALE: begin
          if (bus_we[0]) prescale_d[7:0]  = bus_wdata[7:0];
          if (bus_we[1]) prescale_d[15:8] = bus_wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // A rising match sets seen even when software clears it in the same cycle.
  always_comb begin
    match_d = match;
    irq_d   = irq_en_q && match;
    seen_d  = seen_q;
    if (seen_clr)          seen_d = 1'b0;
    if (match && !match_q) seen_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      cmp_q      <= CMP_RESET;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      seen_q     <= 1'b0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      seen_q     <= seen_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

  // Read data is zero when not selected so responders can be OR-combined.
  always_comb begin
    bus_rdata = '0;
    if (bus_hit && bus_re) begin
      unique case (off)
        OFF_MTIME_LO: bus_rdata = mtime_q[31:0];
        OFF_MTIME_HI: bus_rdata = mtime_q[63:32];
        OFF_CMP_LO:   bus_rdata = cmp_q[31:0];
        OFF_CMP_HI:   bus_rdata = cmp_q[63:32];
        OFF_CTRL:     bus_rdata = {30'd0, irq_en_q, en_q};
        OFF_PRESCALE: bus_rdata = {16'd0, prescale_q};
        OFF_STATUS:   bus_rdata = {30'd0, seen_q, match};
        default:      bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus
// traffic, all compared against a cycle-level arithmetic model of the timer.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic        timer_irq;

  int n_total = 0;
  int n_bad   = 0;

  bus_timer #(.BASE_ADDR(BASE), .ADDR_BITS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-register values and plain arithmetic.
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_irq_en, m_seen, m_match_prev, m_irq;
  int unsigned m_ps, m_pc;

  task automatic model_reset();
    m_mtime = 0; m_cmp = '1; m_en = 0; m_irq_en = 0;
    m_ps = 0; m_pc = 0; m_seen = 0; m_match_prev = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] lane_write(input logic [31:0] old_v, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (wd & mask);
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return (a >> 5) == (BASE >> 5);
  endfunction

  function automatic logic [31:0] model_read(input logic re, input logic [31:0] a);
    logic match;
    match = m_mtime >= m_cmp;
    if (!re || !model_hit(a)) return 0;
    case (a[4:2])
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_irq_en, m_en};
      3'd5: return m_ps;
      3'd6: return {30'd0, m_seen, match};
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    logic        tick, match, wr;
    logic [31:0] ctrl_w;
    logic [63:0] next_mtime;
    int unsigned next_pc;
    wr     = model_hit(a) && (we != 0);
    tick   = m_en && (m_pc == m_ps);
    match  = m_mtime >= m_cmp;
    next_pc    = (!m_en || tick) ? 0 : m_pc + 1;
    next_mtime = tick ? m_mtime + 1 : m_mtime;
    m_irq  = m_irq_en && match;
    if (match && !m_match_prev) m_seen = 1;
    else if (wr && a[4:2] == 3'd6 && we[0] && wd[1]) m_seen = 0;
    m_match_prev = match;
    if (wr) begin
      case (a[4:2])
        3'd0: next_mtime = {m_mtime[63:32], lane_write(m_mtime[31:0], wd, we)};
        3'd1: next_mtime = {lane_write(m_mtime[63:32], wd, we), m_mtime[31:0]};
        3'd2: m_cmp = {m_cmp[63:32], lane_write(m_cmp[31:0], wd, we)};
        3'd3: m_cmp = {lane_write(m_cmp[63:32], wd, we), m_cmp[31:0]};
        3'd4: begin
          ctrl_w   = lane_write({30'd0, m_irq_en, m_en}, wd, we);
          m_en     = ctrl_w[0];
          m_irq_en = ctrl_w[1];
        end
        3'd5: begin
          m_ps    = lane_write(m_ps, wd, we) & 32'hFFFF;
          next_pc = 0;
        end
        default: ;
      endcase
    end
    m_mtime = next_mtime;
    m_pc    = next_pc;
  endtask

  // One bus cycle: drive on the falling edge, sample just after, clock the model.
  task automatic cyc(input logic re, input logic [3:0] we, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rv, output logic irq_s);
    @(negedge clk);
    bus_re = re; bus_we = we; bus_addr = a; bus_wdata = wd;
    #1;
    rv    = bus_rdata;
    irq_s = timer_irq;
    check("hit", bus_hit, model_hit(a));
    check($sformatf("rdata@%0h", a[4:0]), bus_rdata, model_read(re, a));
    check("irq", timer_irq, m_irq);
    @(posedge clk);
    model_step(we, a, wd);
  endtask

  logic [31:0] rv;
  logic        irq_s;

  task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] be = 4'hF);
    cyc(1'b0, be, BASE + {27'd0, o, 2'b00}, d, rv, irq_s);
  endtask

  task automatic rd(input logic [2:0] o);
    cyc(1'b1, 4'h0, BASE + {27'd0, o, 2'b00}, 32'h0, rv, irq_s);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, BASE, 32'h0, rv, irq_s);
  endtask

  logic [31:0] reset_vals [8];

  initial begin
    reset_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; bus_re = 0; bus_we = 0; bus_addr = BASE; bus_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every register
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      check($sformatf("reset_reg%0d", i), rv, reset_vals[i]);
    end
    check("reset_irq", irq_s, 1'b0);

    // Prescaled counting, then freeze
    wr(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    repeat (40) idle();
    rd(3'd0);
    check("presc_count", rv, 32'd10);
    wr(3'd4, 32'd0);
    repeat (20) idle();
    rd(3'd0);
    check("frozen", rv, 32'd10);

    // 64-bit carry and write-wins-over-tick
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'h0);
    wr(3'd5, 32'd0);
    wr(3'd4, 32'd1);
    idle();
    rd(3'd0);
    check("carry_lo", rv, 32'd0);
    rd(3'd1);
    check("carry_hi", rv, 32'd1);
    wr(3'd0, 32'd5);
    rd(3'd0);
    check("write_wins", rv, 32'd5);

    // Compare, irq, seen and W1C
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd20);
    wr(3'd4, 32'd3);
    irq_s = 1'b0;
    for (int i = 0; i < 100 && !irq_s; i++) rd(3'd0);
    check("irq_rise", irq_s, 1'b1);
    check("irq_rise_mtime", rv, 32'd21);
    rd(3'd6);
    check("status_seen", rv, 32'd3);
    wr(3'd2, 32'd1000);
    rd(3'd6);
    check("irq_hold_1clk", irq_s, 1'b1);
    check("status_nomatch", rv, 32'd2);
    idle();
    check("irq_fall", irq_s, 1'b0);
    wr(3'd6, 32'd2);
    rd(3'd6);
    check("seen_w1c", rv, 32'd0);

    // Byte lanes and out-of-window access
    wr(3'd4, 32'd0);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd2, 32'hAABB_CCDD, 4'b0010);
    rd(3'd2);
    check("byte_lane", rv, 32'hFFFF_CCFF);
    cyc(1'b1, 4'hF, BASE + 32'h40, 32'h0, rv, irq_s);
    check("miss_rdata", rv, 32'd0);
    rd(3'd2);
    check("miss_nochange", rv, 32'hFFFF_CCFF);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      logic        re;
      a  = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? BASE + 32'h40 : $urandom;
      re = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      d  = $urandom;
      if (a[4:2] == 3'd5 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 3);
      if (a[4:2] == 3'd1 || a[4:2] == 3'd3) d = $urandom_range(0, 1);
      cyc(re, be, a, d, rv, irq_s);
    end

    // Asynchronous reset with irq high
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd5, 32'd0);
    wr(3'd4, 32'd3);
    repeat (3) idle();
    check("irq_before_rst", irq_s, 1'b1);
    @(negedge clk);
    bus_we = 0;
    #2 rst = 1'b1;
    #1 check("irq_async_clear", timer_irq, 1'b0);
    bus_re = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_addr = BASE + 32'(i * 4);
      #0.5;
      check($sformatf("rst_reg%0d", i), bus_rdata, reset_vals[i]);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) rd(3'd0);
    check("post_rst_mtime", rv, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
